// File: rtl/gmii_rx_pkg.sv
// Shared definitions for the GMII video/audio UDP receive path.
// Holds parser state encodings, packet ident codes, protocol constants,
// the CRC-32 residue and a byte-wise CRC-32 step function.
package gmii_rx_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_IDENT, S_RESOL,
    S_VIDEO, S_AUXID, S_AUX, S_FCS, S_WAIT_END, S_DROP
  } rx_state_e;

  localparam logic [7:0]  ID_VIDEO        = 8'd0;
  localparam logic [7:0]  ID_AUDIO        = 8'd1;
  localparam logic [7:0]  ID_VIDAX        = 8'd2;

  localparam logic [7:0]  PREAMBLE        = 8'h55;
  localparam logic [7:0]  SFD             = 8'hD5;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL      = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;

  localparam logic [10:0] ETH_HDR         = 11'd14;
  localparam logic [10:0] IP_HDR          = 11'd20;
  localparam logic [10:0] UDP_HDR         = 11'd8;

  localparam logic [5:0]  AUX_GROUP_BYTES = 6'd50;

  localparam logic [31:0] CRC_POLY        = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE     = 32'hC704DD7B;

  // Non-reflected CRC-32 register; Ethernet bytes enter LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[31] ^ d[i]) ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/gmii_rx_crc32_chk.sv
// Byte-wise CRC-32 checker. Cleared by init (on SFD), advanced on en, and
// ok reports that the register holds the good-frame residue, i.e. the bytes
// fed so far (data followed by FCS) form a valid frame.
//  clk, rst_n : clock, async active-low reset
//  init       : preset register to all ones
//  en         : consume byte d
//  ok         : residue match
module gmii_rx_crc32_chk
  import gmii_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] d,
  output logic       ok
);

  logic [31:0] crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= '1;
    else if (init) crc <= '1;
    else if (en)   crc <= crc32_byte(crc, d);
  end

  assign ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx.sv
// GMII receiver for the video/audio UDP link. Filters on MAC/ethertype/IP
// protocol/UDP port, then splits the payload into a video line (header +
// pixel pairs) and/or AUX groups (AUXID + 3-byte words), and reports the
// FCS verdict as a single frame_ok/frame_err pulse when rx_dv falls.
//  rx_clk, sys_rst_n          : clock, async active-low reset
//  id                         : board id, lowers last dst MAC byte
//  rx_dv, rx_er, rxd          : GMII receive interface
//  vid_hdr_wr/vid_hdr         : line header strobe/value
//  vid_wr_en/vid_data         : pixel pair strobe/value
//  aux_hdr_wr/aux_hdr         : AUXID strobe/value
//  aux_wr_en/aux_data         : AUX word strobe/value
//  pkt_type                   : ident of last accepted frame
//  frame_ok/frame_err         : end-of-frame verdict pulses
module gmii_rx
  import gmii_rx_pkg::*;
#(
  parameter logic [47:0] MY_MAC      = 48'h002345678902,
  parameter logic [15:0] UDP_PORT    = 16'h3039,
  parameter logic [10:0] VIDEO_BYTES = 11'd1280,
  parameter logic [5:0]  AUX_GROUP   = AUX_GROUP_BYTES
) (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        vid_hdr_wr,
  output logic [15:0] vid_hdr,
  output logic        vid_wr_en,
  output logic [15:0] vid_data,
  output logic        aux_hdr_wr,
  output logic [15:0] aux_hdr,
  output logic        aux_wr_en,
  output logic [23:0] aux_data,
  output logic [1:0]  pkt_type,
  output logic        frame_ok,
  output logic        frame_err
);

  rx_state_e   state, state_d;
  logic [7:0]  rxd_r, b0, b1, exp_dst;
  logic        dv_r, er_r, err, err_set, ok_d, bad_d, crc_ok, crc_init, crc_en, short_len;
  logic [10:0] cnt;
  logic [1:0]  ph;
  logic [15:0] udp_len, payload_left, pl_dec, pl_init;
  logic [47:0] dst_mac;

  assign dst_mac   = {MY_MAC[47:8], MY_MAC[7:0] - {7'd0, id}};
  assign pl_dec    = payload_left - 16'd1;
  assign pl_init   = udp_len - 16'd9;     // minus UDP header and ident byte
  assign short_len = udp_len < 16'd9;
  assign crc_en    = dv_r && (state inside {[S_ETH:S_FCS]});

  // Where to go once a payload section is done, given the bytes still owed.
  function automatic rx_state_e after_sect(input logic [15:0] pl);
    if (pl == 16'd0)                   return S_FCS;
    else if (pl < {10'd0, AUX_GROUP})  return S_WAIT_END;
    else                               return S_AUXID;
  endfunction

  always_comb begin
    case (cnt[2:0])
      3'd0:    exp_dst = dst_mac[47:40];
      3'd1:    exp_dst = dst_mac[39:32];
      3'd2:    exp_dst = dst_mac[31:24];
      3'd3:    exp_dst = dst_mac[23:16];
      3'd4:    exp_dst = dst_mac[15:8];
      default: exp_dst = dst_mac[7:0];
    endcase
  end

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d  = state;
    err_set  = 1'b0;
    ok_d     = 1'b0;
    bad_d    = 1'b0;
    crc_init = 1'b0;
    case (state)
      S_IDLE: if (dv_r) state_d = (rxd_r == PREAMBLE) ? S_PRE : S_DROP;
      S_PRE: begin
        if (rxd_r == SFD) begin
          state_d  = S_ETH;
          crc_init = 1'b1;
        end else if (rxd_r != PREAMBLE) state_d = S_DROP;
      end
      S_ETH: begin
        if ((cnt < 11'd6 && rxd_r != exp_dst) ||
            (cnt == 11'd12 && rxd_r != ETHERTYPE_IPV4[15:8]) ||
            (cnt == 11'd13 && rxd_r != ETHERTYPE_IPV4[7:0]))
          state_d = S_DROP;
        else if (cnt == ETH_HDR - 11'd1) state_d = S_IP;
      end
      S_IP: begin
        if ((cnt == 11'd0 && rxd_r != IP_VER_IHL) || (cnt == 11'd9 && rxd_r != IP_PROTO_UDP))
          state_d = S_DROP;
        else if (cnt == IP_HDR - 11'd1) state_d = S_UDP;
      end
      S_UDP: begin
        if ((cnt == 11'd2 && rxd_r != UDP_PORT[15:8]) || (cnt == 11'd3 && rxd_r != UDP_PORT[7:0]))
          state_d = S_DROP;
        else if (cnt == UDP_HDR - 11'd1) state_d = S_IDENT;
      end
      S_IDENT: begin
        case (rxd_r)
          ID_VIDEO, ID_VIDAX: begin
            if (short_len || pl_init < {5'd0, VIDEO_BYTES} + 16'd2) begin
              state_d = S_WAIT_END;
              err_set = 1'b1;
            end else state_d = S_RESOL;
          end
          ID_AUDIO: begin
            state_d = short_len ? S_WAIT_END : after_sect(pl_init);
            err_set = (state_d == S_WAIT_END);
          end
          default: state_d = S_DROP;
        endcase
      end
      S_RESOL: if (cnt == 11'd1) state_d = S_VIDEO;
      S_VIDEO: begin
        if (cnt == VIDEO_BYTES - 11'd1) begin
          state_d = after_sect(pl_dec);
          err_set = (state_d == S_WAIT_END);
        end
      end
      S_AUXID: if (cnt == 11'd1) state_d = S_AUX;
      S_AUX: begin
        if (cnt == {5'd0, AUX_GROUP} - 11'd3) begin
          state_d = after_sect(pl_dec);
          err_set = (state_d == S_WAIT_END);
        end
      end
      S_FCS: if (cnt == 11'd3) state_d = S_WAIT_END;
      default: ;
    endcase
    // dv fall ends every frame; only frames past the filters get a verdict.
    if (!dv_r && state != S_IDLE) begin
      state_d  = S_IDLE;
      err_set  = 1'b0;
      crc_init = 1'b0;
      if (state inside {[S_IDENT:S_WAIT_END]}) begin
        ok_d  = (state == S_WAIT_END) && !err && crc_ok;
        bad_d = !ok_d;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_r <= '0; dv_r <= 1'b0; er_r <= 1'b0;
      cnt <= '0; ph <= '0; udp_len <= '0; payload_left <= '0;
      b0 <= '0; b1 <= '0; err <= 1'b0;
      vid_hdr_wr <= 1'b0; vid_hdr <= '0; vid_wr_en <= 1'b0; vid_data <= '0;
      aux_hdr_wr <= 1'b0; aux_hdr <= '0; aux_wr_en <= 1'b0; aux_data <= '0;
      pkt_type <= '0; frame_ok <= 1'b0; frame_err <= 1'b0;
    end else begin
      rxd_r <= rxd;
      dv_r  <= rx_dv;
      er_r  <= rx_er;
      cnt   <= (state_d != state) ? '0 : cnt + 11'd1;
      ph    <= (state == S_AUX && ph != 2'd2) ? ph + 2'd1 : '0;
      err   <= (state == S_IDLE) ? 1'b0
             : (err | err_set | (er_r && state != S_PRE && state != S_DROP));
      frame_ok   <= ok_d;
      frame_err  <= bad_d;
      vid_hdr_wr <= 1'b0;
      vid_wr_en  <= 1'b0;
      aux_hdr_wr <= 1'b0;
      aux_wr_en  <= 1'b0;
      if (dv_r) begin
        case (state)
          S_UDP: begin
            if (cnt == 11'd4) udp_len[15:8] <= rxd_r;
            if (cnt == 11'd5) udp_len[7:0]  <= rxd_r;
          end
          S_IDENT: begin
            payload_left <= pl_init;
            if (state_d != S_DROP) pkt_type <= rxd_r[1:0];
          end
          S_RESOL, S_AUXID: begin
            payload_left <= pl_dec;
            if (!cnt[0]) b0 <= rxd_r;
            else if (state == S_RESOL) begin
              vid_hdr_wr <= 1'b1;
              vid_hdr    <= {b0, rxd_r};
            end else begin
              aux_hdr_wr <= 1'b1;
              aux_hdr    <= {b0, rxd_r};
            end
          end
          S_VIDEO: begin
            payload_left <= pl_dec;
            if (!cnt[0]) b0 <= rxd_r;
            else begin
              vid_wr_en <= 1'b1;
              vid_data  <= {b0, rxd_r};
            end
          end
          S_AUX: begin
            payload_left <= pl_dec;
            case (ph)
              2'd0:    b0 <= rxd_r;
              2'd1:    b1 <= rxd_r;
              default: begin
                aux_wr_en <= 1'b1;
                aux_data  <= {b0, b1, rxd_r};
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  gmii_rx_crc32_chk u_crc (
    .clk   (rx_clk),
    .rst_n (sys_rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .d     (rxd_r),
    .ok    (crc_ok)
  );

endmodule

// File: tb/tb_gmii_rx.sv
// Directed bench for gmii_rx: builds complete Ethernet/IPv4/UDP frames with
// a reflected-CRC FCS and checks strobe counts, data,
// latency and the frame verdict for good, filtered and damaged frames.
module tb_gmii_rx;

  logic        rx_clk = 1'b0, sys_rst_n = 1'b0, id = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        vid_hdr_wr, vid_wr_en, aux_hdr_wr, aux_wr_en, frame_ok, frame_err;
  logic [15:0] vid_hdr, vid_data, aux_hdr;
  logic [23:0] aux_data;
  logic [1:0]  pkt_type;
  logic [79:0] all_outs;

  gmii_rx dut (
    .rx_clk(rx_clk), .sys_rst_n(sys_rst_n), .id(id), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .vid_hdr_wr(vid_hdr_wr), .vid_hdr(vid_hdr), .vid_wr_en(vid_wr_en), .vid_data(vid_data),
    .aux_hdr_wr(aux_hdr_wr), .aux_hdr(aux_hdr), .aux_wr_en(aux_wr_en), .aux_data(aux_data),
    .pkt_type(pkt_type), .frame_ok(frame_ok), .frame_err(frame_err)
  );

  assign all_outs = {vid_hdr_wr, vid_hdr, vid_wr_en, vid_data, aux_hdr_wr, aux_hdr,
                     aux_wr_en, aux_data, pkt_type, frame_ok, frame_err};

  always #4 rx_clk = ~rx_clk;

  int cyc;
  always @(posedge rx_clk) cyc++;

  // Strobe monitor, sampled on the inactive edge.
  int          n_vhdr, n_vid, n_ahdr, n_aux, n_ok, n_err, t_vhdr;
  logic [15:0] l_vhdr, f_vid, l_vid, l_ahdr;
  logic [23:0] l_aux;
  logic        want_first = 1'b0;
  always @(negedge rx_clk) begin
    if (vid_hdr_wr) begin n_vhdr++; l_vhdr = vid_hdr; t_vhdr = cyc; want_first = 1'b1; end
    if (vid_wr_en) begin
      n_vid++; l_vid = vid_data;
      if (want_first) begin f_vid = vid_data; want_first = 1'b0; end
    end
    if (aux_hdr_wr) begin n_ahdr++; l_ahdr = aux_hdr; end
    if (aux_wr_en)  begin n_aux++;  l_aux  = aux_data; end
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
  end

  int checks = 0, passed = 0;
  int b_vhdr, b_vid, b_ahdr, b_aux, b_ok, b_err;
  int r_vhdr, r_vid, r_ahdr, r_aux, r_ok, r_err;
  int t_drive;
  logic [7:0] fr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic snap();
    b_vhdr = n_vhdr; b_vid = n_vid; b_ahdr = n_ahdr; b_aux = n_aux; b_ok = n_ok; b_err = n_err;
  endtask

  task automatic check_frame(input string tag, input int vhdr, input int vid, input int ahdr,
                             input int aux, input int ok, input int err);
    check({tag, ".vhdr"}, n_vhdr - b_vhdr, vhdr);
    check({tag, ".vid"},  n_vid  - b_vid,  vid);
    check({tag, ".ahdr"}, n_ahdr - b_ahdr, ahdr);
    check({tag, ".aux"},  n_aux  - b_aux,  aux);
    check({tag, ".ok"},   n_ok   - b_ok,   ok);
    check({tag, ".err"},  n_err  - b_err,  err);
  endtask

  // 43 header bytes: Ethernet, IPv4, UDP, ident.
  task automatic build_hdr(input logic [7:0] dst5, input logic [15:0] port,
                           input logic [15:0] ulen, input logic [7:0] ident);
    logic [15:0]  iplen;
    logic [343:0] h;
    iplen = ulen + 16'd20;
    h = {40'h0023456789, dst5, 48'h021122334455, 16'h0800, 16'h4500, iplen, 32'h0000_4000,
         16'h4011, 16'h0000, 32'hC0A80002, 32'hC0A80003, 16'h3039, port, ulen, 16'h0000, ident};
    fr.delete();
    for (int i = 0; i < 43; i++) fr.push_back(h[343 - 8*i -: 8]);
  endtask

  task automatic add_video(input logic [15:0] hdr);
    fr.push_back(hdr[15:8]);
    fr.push_back(hdr[7:0]);
    for (int i = 0; i < 1280; i++) fr.push_back(i[7:0]);
  endtask

  task automatic add_aux(input int g);
    int v;
    fr.push_back(8'h20 + g[7:0]);
    fr.push_back(g[7:0]);
    for (int k = 0; k < 48; k++) begin v = g*48 + k; fr.push_back(v[7:0]); end
  endtask

  // Reflected CRC-32, complemented, appended LSB first.
  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fr[i]) begin
      c = c ^ {24'h0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
  endtask

  task automatic send(input int er_at, input int drop_at, input int rst_at);
    repeat (7) begin @(negedge rx_clk); rx_dv = 1'b1; rxd = 8'h55; end
    @(negedge rx_clk); rxd = 8'hD5;
    for (int i = 0; i < fr.size() && i != drop_at; i++) begin
      @(negedge rx_clk);
      rxd = fr[i];
      rx_er = (i == er_at);
      sys_rst_n = (i != rst_at);
      if (i == 44) t_drive = cyc;
      if (i == rst_at) begin
        #1;
        check("rst_mid.outs_zero", {31'd0, |all_outs}, 32'd0);
        r_vhdr = n_vhdr; r_vid = n_vid; r_ahdr = n_ahdr; r_aux = n_aux; r_ok = n_ok; r_err = n_err;
      end
    end
    @(negedge rx_clk);
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; sys_rst_n = 1'b1;
    repeat (12) @(negedge rx_clk);
  endtask

  initial begin
    repeat (3) @(negedge rx_clk);
    check("reset.outs_zero", {31'd0, |all_outs}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge rx_clk);

    // Video only: 2B header + 1280 ramp bytes.
    build_hdr(8'h02, 16'h3039, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("video", 1, 640, 0, 0, 1, 0);
    check("video.hdr", {16'd0, l_vhdr}, 32'h0A12);
    check("video.first", {16'd0, f_vid}, 32'h0001);
    check("video.last", {16'd0, l_vid}, 32'hFEFF);
    check("video.latency", t_vhdr - t_drive, 2);
    check("video.pkt_type", {30'd0, pkt_type}, 0);

    // Audio: three AUX groups.
    build_hdr(8'h02, 16'h3039, 16'd159, 8'd1);
    for (int g = 0; g < 3; g++) add_aux(g);
    add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("audio", 0, 0, 3, 48, 1, 0);
    check("audio.ahdr", {16'd0, l_ahdr}, 32'h2202);
    check("audio.last", {8'd0, l_aux}, 32'h8D8E8F);
    check("audio.pkt_type", {30'd0, pkt_type}, 1);

    // Video followed by one AUX group.
    build_hdr(8'h02, 16'h3039, 16'd1341, 8'd2); add_video(16'h0B34); add_aux(0); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("vidax", 1, 640, 1, 16, 1, 0);
    check("vidax.last_aux", {8'd0, l_aux}, 32'h2D2E2F);
    check("vidax.pkt_type", {30'd0, pkt_type}, 2);

    // Filtered frames: silent.
    build_hdr(8'h03, 16'h3039, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("bad_mac", 0, 0, 0, 0, 0, 0);
    build_hdr(8'h02, 16'h3038, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("bad_port", 0, 0, 0, 0, 0, 0);

    // Board id 1 lowers the last MAC byte.
    id = 1'b1;
    build_hdr(8'h01, 16'h3039, 16'd1291, 8'd0); add_video(16'h0C56); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("id1", 1, 640, 0, 0, 1, 0);
    check("id1.hdr", {16'd0, l_vhdr}, 32'h0C56);
    id = 1'b0;

    // Corrupted payload bit.
    build_hdr(8'h02, 16'h3039, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    fr[100] = fr[100] ^ 8'h04;
    snap(); send(-1, -1, -1);
    check_frame("crc_bad", 1, 640, 0, 0, 0, 1);

    // rx_er at byte 200.
    build_hdr(8'h02, 16'h3039, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    snap(); send(200, -1, -1);
    check_frame("rx_er", 1, 640, 0, 0, 0, 1);

    // dv drop at byte 600: 555 video bytes seen.
    snap(); send(-1, 600, -1);
    check_frame("dv_drop", 1, 277, 0, 0, 0, 1);

    // Payload shorter than one AUX group.
    build_hdr(8'h02, 16'h3039, 16'd39, 8'd1);
    for (int k = 0; k < 30; k++) fr.push_back(k[7:0]);
    add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("short", 0, 0, 0, 0, 0, 1);

    // Reset mid-VIDEO: nothing after it.
    build_hdr(8'h02, 16'h3039, 16'd1291, 8'd0); add_video(16'h0A12); add_fcs();
    snap(); send(-1, -1, 700);
    check("rst_mid.vid_after", n_vid - r_vid, 0);
    check("rst_mid.vhdr_after", n_vhdr - r_vhdr, 0);
    check("rst_mid.ok_after", n_ok - r_ok, 0);
    check("rst_mid.err_after", n_err - r_err, 0);

    // Next frame decodes fully.
    build_hdr(8'h02, 16'h3039, 16'd1291, 8'd0); add_video(16'h0D78); add_fcs();
    snap(); send(-1, -1, -1);
    check_frame("post_rst", 1, 640, 0, 0, 1, 0);
    check("post_rst.hdr", {16'd0, l_vhdr}, 32'h0D78);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
